// File: rtl/booth_ctrl_pkg.sv
// Shared types for the booth multiplier sharing controller.
//   state_t : controller FSM encoding
//   PROD_W  : width of the product returned to requesters ({A,Q} bytes)
package booth_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      LOAD_M  = 3'd2,
      LOAD_Q  = 3'd3,
      WAIT    = 3'd4,
      READ_LO = 3'd5,
      RESP    = 3'd6
   } state_t;

   localparam int PROD_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  index with highest priority this round
//   gnt  out N   one-hot winner, 0 when req is 0
//   idx  out IW  binary index of the winner (0 when req is 0)
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic          found;
   logic [IW:0]   pos;
   logic [IW-1:0] slot;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      slot  = '0;
      for (int k = 0; k < N; k++) begin
         // ptr + k folded back into 0..N-1 without a divider
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(N)) begin
            pos = pos - (IW+1)'(N);
         end
         slot = pos[IW-1:0];
         if (!found && req[slot]) begin
            found     = 1'b1;
            gnt[slot] = 1'b1;
            idx       = slot;
         end
      end
   end

endmodule

// File: rtl/booth_share_ctrl.sv
// Shares one byte-serial booth multiplier between N_REQ requesters.
// A round-robin winner's operands are streamed over mul_inbus, the two
// product bytes are collected from mul_outbus and returned with a one-cycle
// rsp_valid pulse. A job that sees no mul_done for TIMEOUT cycles in WAIT
// returns rsp_err=1 with a zero product.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req[N_REQ]            per-requester request, held until its rsp_valid
//   op_m, op_q            8-bit operand slices, slice i belongs to req[i]
//   gnt[N_REQ]            one-hot owner, 0 when idle
//   busy                  job in flight
//   rsp_valid[N_REQ]      one-cycle pulse to the owner
//   rsp_product, rsp_err  result, qualified by rsp_valid
//   mul_enable, mul_inbus start pulse and operand bus to the multiplier
//   mul_done, mul_outbus  completion strobe and result bytes (A then Q)
module booth_share_ctrl
   import booth_ctrl_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [8*N_REQ-1:0]  op_m,
   input  logic [8*N_REQ-1:0]  op_q,
   output logic [N_REQ-1:0]    gnt,
   output logic                busy,
   output logic [N_REQ-1:0]    rsp_valid,
   output logic [PROD_W-1:0]   rsp_product,
   output logic                rsp_err,
   output logic                mul_enable,
   output logic [7:0]          mul_inbus,
   input  logic                mul_done,
   input  logic [7:0]          mul_outbus
);

   localparam int IW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT);

   state_t              state;
   logic [N_REQ-1:0]    gnt_r;
   logic [IW-1:0]       win;
   logic [IW-1:0]       ptr;
   logic [TW-1:0]       tcnt;
   logic [PROD_W-1:0]   prod;
   logic                err;

   logic [N_REQ-1:0]    arb_gnt;
   logic [IW-1:0]       arb_idx;
   logic [IW+2:0]       base;

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IW)
   ) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt_r <= '0;
         win   <= '0;
         ptr   <= '0;
         tcnt  <= '0;
         prod  <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt_r <= arb_gnt;
                  win   <= arb_idx;
                  err   <= 1'b0;
                  state <= START;
               end
            end
            START:  state <= LOAD_M;
            LOAD_M: state <= LOAD_Q;
            LOAD_Q: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (mul_done) begin
                  prod[15:8] <= mul_outbus;
                  state      <= READ_LO;
               end else if (tcnt == TW'(TIMEOUT-1)) begin
                  // abort skips READ_LO; the zero product goes straight out
                  err   <= 1'b1;
                  prod  <= '0;
                  state <= RESP;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            READ_LO: begin
               prod[7:0] <= mul_outbus;
               state     <= RESP;
            end
            RESP: begin
               ptr   <= (win == IW'(N_REQ-1)) ? '0 : win + IW'(1);
               gnt_r <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign base = {win, 3'b000};

   // operands are read live; the owner keeps them stable while req is high
   always_comb begin
      mul_inbus = '0;
      case (state)
         LOAD_M:  mul_inbus = op_m[base +: 8];
         LOAD_Q:  mul_inbus = op_q[base +: 8];
         default: mul_inbus = '0;
      endcase
   end

   assign gnt         = gnt_r;
   assign busy        = (state != IDLE);
   assign rsp_valid   = (state == RESP) ? gnt_r : '0;
   assign rsp_product = prod;
   assign rsp_err     = err;
   assign mul_enable  = (state == START);

endmodule
